// File: rtl/tanh_backward_seq_ctrl.sv
// tanh_backward_seq_ctrl: steps the tanh backward datapath over stored time steps and writes each result back
module tanh_backward_seq_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 64,
  parameter int HID_DIM = 4,
  parameter int N_LEN   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [ADDR_W:0]            n_steps,
  input  logic                       reverse,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic                       blk_run,
  input  logic                       blk_valid,
  input  logic [HID_DIM*N_LEN-1:0]   q_backward,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [HID_DIM*N_LEN-1:0]   wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_timeout
);
  localparam int FW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] MAXN = (ADDR_W+1)'(2**ADDR_W);
  typedef enum logic [2:0] {IDLE, FETCH, RUN, WRITE, DONE, ERR} state_t;
  state_t st, nxt;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [ADDR_W-1:0] idx, last_idx;
  logic [ADDR_W:0] n_cl;
  logic rev, go, last;
  assign n_cl = n_steps > MAXN ? MAXN : n_steps;
  assign go = st == IDLE && start && !abort;
  assign last = idx == last_idx;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = go ? (n_steps == '0 ? DONE : FETCH) : IDLE;
      FETCH:   nxt = abort ? IDLE : fcnt == FW'(MEM_LAT-1) ? RUN : FETCH;
      RUN:     nxt = abort ? IDLE : blk_valid ? WRITE : tcnt == TW'(TIMEOUT-1) ? ERR : RUN;
      WRITE:   nxt = abort ? IDLE : last ? DONE : FETCH;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      fcnt        <= '0;
      tcnt        <= '0;
      idx         <= '0;
      last_idx    <= '0;
      rd_addr     <= '0;
      rev         <= 1'b0;
      wr_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      st   <= nxt;
      fcnt <= st == FETCH ? fcnt + 1'b1 : '0;
      tcnt <= st == RUN ? tcnt + 1'b1 : '0;
      if (go) begin
        rev         <= reverse;
        idx         <= '0;
        last_idx    <= ADDR_W'(n_cl - 1'b1);
        rd_addr     <= reverse ? ADDR_W'(n_cl - 1'b1) : '0;
        err_timeout <= 1'b0;
      end
      if (st == RUN && nxt == WRITE)
        wr_data <= q_backward;
      // the address only moves between steps, so it can never wrap past the ends
      if (st == WRITE && nxt == FETCH) begin
        idx     <= idx + 1'b1;
        rd_addr <= rev ? rd_addr - 1'b1 : rd_addr + 1'b1;
      end
      if (st == ERR && !abort)
        err_timeout <= 1'b1;
    end
  end
  assign rd_en   = st == FETCH && fcnt == '0;
  assign blk_run = st == RUN;
  assign wr_en   = st == WRITE;
  assign wr_addr = rd_addr;
  assign busy    = st == FETCH || st == RUN || st == WRITE;
  assign done    = st == DONE;
endmodule

// File: tb/tb_tanh_backward_seq_ctrl.sv
// tb_tanh_backward_seq_ctrl: per-cycle timeline model of the step sequencer with a simple datapath stub
module tb_tanh_backward_seq_ctrl;
  localparam int AW = 5, ML = 1, TO = 64, DW = 32;
  typedef struct packed {
    logic rd_en, blk_run, wr_en, busy, done, err;
    logic [AW-1:0] addr;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, reverse = 0, stray = 0, chk_on = 0;
  logic [AW:0] n_steps = '0;
  logic rd_en, blk_run, blk_valid, wr_en, busy, done, err_timeout;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] q_backward, wr_data;
  logic [DW-1:0] qmem [32];
  int lat = 5, run_cnt = 0, checks = 0, errs = 0, dur;
  logic model_err = 0;
  exp_t q[$];
  exp_t ce;
  logic [AW-1:0] wlog[$];

  tanh_backward_seq_ctrl #(.ADDR_W(AW), .MEM_LAT(ML), .TIMEOUT(TO), .HID_DIM(4), .N_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_steps(n_steps), .reverse(reverse),
    .rd_en(rd_en), .rd_addr(rd_addr), .blk_run(blk_run), .blk_valid(blk_valid), .q_backward(q_backward),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err_timeout(err_timeout));

  always #5 clk = ~clk;
  // datapath stub: valid on the lat-th consecutive run cycle; stray valids only while not running
  always @(posedge clk) run_cnt <= blk_run ? run_cnt + 1 : 0;
  assign blk_valid = (lat > 0 && blk_run && run_cnt == lat - 1) | (stray && !blk_run);
  assign q_backward = qmem[rd_addr];

  function automatic exp_t mk(bit re, bit br, bit we, bit bz, bit dn, bit er, int a);
    exp_t e;
    e.rd_en = re; e.blk_run = br; e.wr_en = we; e.busy = bz; e.done = dn; e.err = er;
    e.addr = AW'(a);
    return e;
  endfunction

  task automatic check(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    ce = q.size() != 0 ? q.pop_front() : mk(0, 0, 0, 0, 0, model_err, 0);
    checks++;
    if ({rd_en, blk_run, wr_en, busy, done, err_timeout} !== {ce.rd_en, ce.blk_run, ce.wr_en, ce.busy, ce.done, ce.err}) begin
      errs++;
      $display("FAIL ctrl @%0t: got rd/run/wr/busy/done/err=%b expected %b", $time,
               {rd_en, blk_run, wr_en, busy, done, err_timeout}, {ce.rd_en, ce.blk_run, ce.wr_en, ce.busy, ce.done, ce.err});
    end
    if (ce.busy) begin
      checks++;
      if (rd_addr !== ce.addr) begin errs++; $display("FAIL rd_addr @%0t: got %0d expected %0d", $time, rd_addr, ce.addr); end
    end
    if (ce.wr_en) begin
      checks += 2;
      wlog.push_back(wr_addr);
      if (wr_addr !== ce.addr) begin errs++; $display("FAIL wr_addr @%0t: got %0d expected %0d", $time, wr_addr, ce.addr); end
      if (wr_data !== qmem[ce.addr]) begin errs++; $display("FAIL wr_data @%0t: got %h expected %h", $time, wr_data, qmem[ce.addr]); end
    end
  end

  // whole-sequence timeline from start: idx 0 is the start cycle; returns index of the DONE/ERR cycle
  task automatic build(int n, bit rev, int l, output int last);
    int ne = n > 32 ? 32 : n;
    q.push_back(mk(0, 0, 0, 0, 0, model_err, 0));
    model_err = 0;
    for (int s = 0; s < ne; s++) begin
      int a = rev ? ne - 1 - s : s;
      for (int f = 0; f < ML; f++) q.push_back(mk(f == 0, 0, 0, 1, 0, 0, a));
      if (l == 0) begin
        for (int r = 0; r < TO; r++) q.push_back(mk(0, 1, 0, 1, 0, 0, a));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        model_err = 1;
        last = q.size() - 1;
        return;
      end
      for (int r = 0; r < l; r++) q.push_back(mk(0, 1, 0, 1, 0, 0, a));
      q.push_back(mk(0, 0, 1, 1, 0, 0, a));
    end
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    last = q.size() - 1;
  endtask

  task automatic run_seq(int n, bit rev, int l, int abort_at, int rst_at, int start2_at, output int last);
    int c;
    @(posedge clk); #1;
    wlog.delete();
    build(n, rev, l, last);
    n_steps = (AW+1)'(n); reverse = rev; lat = l; start = 1; stray = 0;
    for (c = 1; c < 3000 && q.size() != 0; c++) begin
      @(posedge clk); #1;
      start = c == start2_at; abort = 0; rst_n = 1;
      n_steps = (AW+1)'($urandom); reverse = 1'($urandom); stray = $urandom_range(0, 3) == 0;
      if (c == abort_at || c == rst_at) begin
        while (q.size() > 1) void'(q.pop_back());
        model_err = 0;
        if (c == abort_at) abort = 1; else rst_n = 0;
      end
    end
    if (q.size() != 0) check("sequence_bound", q.size(), 0);
    @(posedge clk); #1;
    start = 0; abort = 0; rst_n = 1; stray = 0;
  endtask

  task automatic idle(int k);
    repeat (k) begin @(posedge clk); #1; stray = $urandom_range(0, 1); end
    stray = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) qmem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1; rst_n = 1; chk_on = 1;
    @(negedge clk); check("reset_wr_data", wr_data, 0);
    idle(3);
    run_seq(3, 0, 5, -1, -1, -1, dur);
    check("t1_done_cycle", dur, 22);
    check("t1_writes", wlog.size(), 3);
    for (int i = 0; i < wlog.size(); i++) check("t1_wr_order", wlog[i], i);
    run_seq(4, 1, $urandom_range(1, 8), -1, -1, -1, dur);
    check("t2_writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size(); i++) check("t2_wr_order", wlog[i], 3 - i);
    run_seq(0, 0, 5, -1, -1, -1, dur);
    check("t3_done_cycle", dur, 1);
    check("t3_writes", wlog.size(), 0);
    run_seq(2, 0, 0, -1, -1, -1, dur);
    check("t4_err_cycle", dur, 66);
    idle(2);
    check("t4_err_sticky", err_timeout, 1);
    @(posedge clk); #1; start = 1; abort = 1; n_steps = 3;
    @(posedge clk); #1; start = 0; abort = 0;
    idle(2);
    check("start_abort_ignored", err_timeout, 1);
    run_seq(1, 0, 3, -1, -1, -1, dur);
    check("t4_err_cleared", err_timeout, 0);
    run_seq(3, 0, 5, 10, -1, -1, dur);
    check("t5_writes", wlog.size(), 1);
    check("t5_busy", busy, 0);
    run_seq(3, 0, 4, -1, 9, 3, dur);
    @(negedge clk);
    check("t6_wr_data_reset", wr_data, 0);
    check("t6_writes", wlog.size(), 1);
    run_seq(40, 1, 1, -1, -1, -1, dur);
    check("clamp_writes", wlog.size(), 32);
    check("clamp_first", wlog.size() > 0 ? wlog[0] : 99, 31);
    for (int k = 0; k < 10; k++) begin
      int n = $urandom_range(0, 40), l = $urandom_range(1, 10);
      run_seq(n, 1'($urandom), l, -1, -1, $urandom_range(0, 1) ? $urandom_range(2, 6) : -1, dur);
      check("rand_writes", wlog.size(), n > 32 ? 32 : n);
      idle($urandom_range(0, 3));
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
